// File: rtl/counter_sweep_ctl.sv
// counter_sweep_ctl
// Drives an external synchronous up/down counter through a run of full
// lo -> hi -> lo sweeps. The counter is loaded with lo once, then counted
// up to hi and back down to lo. That round trip is repeated ncycles times.
// The counter acts on the same rising edge that this controller uses to
// change state. The controller gates the count enable combinationally
// from ctr_q, so the counter never steps past either bound.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : request a run (only looked at in IDLE)
//   stop       : abort the current run (ignored in IDLE)
//   lo, hi     : sweep bounds, latched when a start is accepted
//   ncycles    : number of full sweeps, latched when a start is accepted
//   ctr_q      : present value of the external counter
//   ctr_d      : parallel load data to the counter (latched lo)
//   ctr_load_n : active-low parallel load
//   ctr_en_n   : active-low count enable
//   ctr_updn   : count direction, 1 = up, 0 = down
//   busy       : high whenever the controller is not in IDLE
//   done       : one-clock pulse when a run completes normally
//   err        : one-clock pulse when a start request is rejected
//   cyc_cnt    : completed sweeps in the current (or last) run
module counter_sweep_ctl #(
    parameter int WIDTH = 4,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [CW-1:0]    ncycles,
    input  logic [WIDTH-1:0] ctr_q,
    output logic [WIDTH-1:0] ctr_d,
    output logic             ctr_load_n,
    output logic             ctr_en_n,
    output logic             ctr_updn,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CW-1:0]    cyc_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_DOWN,
        S_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] lo_reg, hi_reg;
    logic [CW-1:0]    n_reg;
    logic [CW-1:0]    cyc_reg, cyc_next;
    logic [CW-1:0]    cyc_inc;
    logic             err_reg;
    logic             req_valid;
    logic             accept;

    // A request is valid only for a non-empty range and a non-zero sweep count.
    assign req_valid = (lo < hi) && (ncycles != '0);
    assign accept    = (state_reg == S_IDLE) && start && req_valid;
    assign cyc_inc   = cyc_reg + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            lo_reg    <= '0;
            hi_reg    <= '0;
            n_reg     <= '0;
            cyc_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cyc_reg   <= cyc_next;
            err_reg   <= (state_reg == S_IDLE) && start && !req_valid;
            if (accept) begin
                lo_reg <= lo;
                hi_reg <= hi;
                n_reg  <= ncycles;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cyc_next   = cyc_reg;
        ctr_load_n = 1'b1;
        ctr_en_n   = 1'b1;
        ctr_updn   = 1'b1;
        done       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    cyc_next   = '0;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                ctr_load_n = 1'b0;
                state_next = S_UP;
            end
            S_UP: begin
                // Hold at hi: the counter then sits there for this clock
                // and for the first DOWN clock, giving the two-clock dwell.
                ctr_en_n = (ctr_q == hi_reg);
                if (ctr_q == hi_reg)
                    state_next = S_DOWN;
            end
            S_DOWN: begin
                ctr_updn = 1'b0;
                ctr_en_n = (ctr_q == lo_reg);
                if (ctr_q == lo_reg) begin
                    cyc_next   = cyc_inc;
                    state_next = (cyc_inc == n_reg) ? S_DONE : S_UP;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Abort overrides everything: freeze the counter in this very clock,
        // keep the sweep count as it was, and never report completion.
        if (stop && (state_reg != S_IDLE)) begin
            ctr_load_n = 1'b1;
            ctr_en_n   = 1'b1;
            done       = 1'b0;
            cyc_next   = cyc_reg;
            state_next = S_IDLE;
        end
    end

    assign ctr_d   = lo_reg;
    assign busy    = (state_reg != S_IDLE);
    assign err     = err_reg;
    assign cyc_cnt = cyc_reg;

endmodule

// File: doc/counter_sweep_ctl.md
COUNTER_SWEEP_CTL -- requirements
Module: counter_sweep_ctl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the bit width of the controlled up/down counter and of bounds lo/hi.
REQ-002 SHALL have parameter CW, default 8, the bit width of the sweep-cycle count.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port start  input  1  request a sweep run; sampled only in IDLE.
REQ-006 SHALL have port stop  input  1  abort the current run.
REQ-007 SHALL have port lo  input  WIDTH  lower sweep bound.
REQ-008 SHALL have port hi  input  WIDTH  upper sweep bound.
REQ-009 SHALL have port ncycles  input  CW  number of full up/down sweeps.
REQ-010 SHALL have port ctr_q  input  WIDTH  present value of the external up/down counter.
REQ-011 SHALL have port ctr_d  output  WIDTH  parallel load data to the counter.
REQ-012 SHALL have port ctr_load_n  output  1  active-low parallel load to the counter.
REQ-013 SHALL have port ctr_en_n  output  1  active-low count enable to the counter.
REQ-014 SHALL have port ctr_updn  output  1  count direction, 1 = up, 0 = down.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port done  output  1  one-clock pulse on normal completion.
REQ-017 SHALL have port err  output  1  one-clock pulse on a rejected start.
REQ-018 SHALL have port cyc_cnt  output  CW  number of completed sweeps in the current run.

Function
REQ-019 SHALL implement states IDLE, LOAD, UP, DOWN, DONE; the external counter counts or loads on the same clk edge.
REQ-020 IDLE: ctr_load_n=1, ctr_en_n=1, ctr_updn=1, ctr_d=lo_r; on start with lo<hi and ncycles!=0, SHALL latch lo, hi, ncycles into lo_r, hi_r, n_r, clear cyc_cnt, and go to LOAD.
REQ-021 IDLE: on start with lo>=hi or ncycles==0, SHALL pulse err for one clock and remain in IDLE.
REQ-022 LOAD: SHALL drive ctr_load_n=0, ctr_d=lo_r, ctr_en_n=1 for exactly one clock, then go to UP.
REQ-023 UP: ctr_updn=1; ctr_en_n SHALL be combinationally 1 when ctr_q==hi_r, else 0; on ctr_q==hi_r go to DOWN.
REQ-024 DOWN: ctr_updn=0; ctr_en_n SHALL be combinationally 1 when ctr_q==lo_r, else 0; on ctr_q==lo_r increment cyc_cnt, then go to DONE if the incremented value equals n_r, else go to UP.
REQ-025 Consequence: the counter SHALL dwell exactly two clocks at each bound and never overshoot lo_r or hi_r.
REQ-026 DONE: SHALL pulse done for one clock, hold cyc_cnt, and return to IDLE.
REQ-027 stop in LOAD, UP, DOWN, or DONE SHALL force ctr_en_n=1 and ctr_load_n=1 combinationally in that clock, go to IDLE next edge, and suppress done; stop in IDLE has no effect.
REQ-028 stop SHALL have priority over all other transitions.
REQ-029 start while busy SHALL be ignored; lo, hi, ncycles changes while busy SHALL NOT affect the run.
REQ-030 cyc_cnt SHALL keep its last value in IDLE until the next accepted start.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, cyc_cnt=0, lo_r=hi_r=n_r=0, done=0, err=0, busy=0, ctr_load_n=1, ctr_en_n=1, ctr_updn=1, ctr_d=0, independent of clk.
REQ-032 Reset asserted mid-run SHALL abandon the run with no done pulse; after release the block SHALL accept a new start normally.

Verification
REQ-033 The bench SHALL attach a behavioral synchronous up/down counter model and cover:
REQ-034 lo=3, hi=6, ncycles=2, start -> ctr_q sequence 3,4,5,6,6,5,4,3,3,4,5,6,6,5,4,3; done pulses once; cyc_cnt=2; busy falls.
REQ-035 lo=6, hi=6, start -> err one-clock pulse, busy stays 0, ctr_load_n stays 1.
REQ-036 lo=0, hi=15, ncycles=1, stop asserted when ctr_q==9 in UP -> ctr_q holds 9, IDLE next clock, no done pulse.
REQ-037 rst asserted mid-DOWN at ctr_q=4 -> all outputs at reset values without a clock edge; subsequent start with lo=1, hi=2, ncycles=1 completes with cyc_cnt=1.
REQ-038 start held high during a run with changed lo/hi -> run uses the latched bounds; no restart occurs until after IDLE is reached.
